// File: rtl/md_lr_pkg.sv
// Shared types and constants for the MD particle loader.
// FSM state encoding and ROM latency legal range.
package md_lr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } pl_state_e;

  localparam int unsigned ROMLAT_MIN = 1;
  localparam int unsigned ROMLAT_MAX = 3;

  function automatic logic romlat_ok(input int unsigned lat);
    return (lat >= ROMLAT_MIN) && (lat <= ROMLAT_MAX);
  endfunction

endpackage

// File: rtl/md_pl_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// Depth need not be a power of two; pointers wrap explicitly.
module md_pl_fifo
  import md_lr_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rptr];

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/md_particle_loader.sv
// Streams particle records from ROM into accelerator particle memory.
// Optional stall counter: define MD_PLOADER_STALLCNT_EN.
module md_particle_loader
  import md_lr_pkg::*;
#(
  parameter int unsigned MAXNUMP = 32'd4096,
  parameter int unsigned PDATAW  = 32'd125,
  parameter int unsigned ROMLAT  = 32'd1,
  localparam int unsigned PADDRW = $clog2(MAXNUMP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PADDRW:0]   nump,
  output logic              busy,
  output logic              done,
  output logic              rom_me,
  output logic [PADDRW-1:0] rom_addr,
  input  logic [PDATAW-1:0] rom_rdata,
  input  logic              pready,
  output logic              pvalid,
  output logic [PADDRW-1:0] paddr,
  output logic              pwe,
  output logic [PDATAW-1:0] pwdata,
  output logic              plast,
  output logic [31:0]       pstall_cnt
);

  localparam int unsigned DEPTH = ROMLAT + 1;
  localparam int unsigned FW    = PADDRW + PDATAW;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [PADDRW:0] MAXN    = (PADDRW + 1)'(MAXNUMP);
  localparam logic [3:0]      CREDITS = 4'(DEPTH);

  if (!romlat_ok(ROMLAT)) begin : g_bad_romlat
    $error("md_particle_loader: ROMLAT out of range");
  end

  pl_state_e         state;
  pl_state_e         state_nxt;
  logic [PADDRW:0]   nump_c;
  logic [PADDRW-1:0] last_addr;
  logic [PADDRW-1:0] rd_addr;
  logic              start_ok;
  logic              issue_ok;
  logic              beat;
  logic              fifo_empty;
  logic [ROMLAT-1:0] sv;
  logic [PADDRW-1:0] sa [ROMLAT];
  logic [CW-1:0]     fcnt;
  logic [3:0]        infl;
  logic [3:0]        used;
  logic [FW-1:0]     head;
  logic [PADDRW-1:0] head_addr;

  assign nump_c   = (nump > MAXN) ? MAXN : nump;
  assign start_ok = start && (state == ST_IDLE);
  assign beat     = pvalid && pready;
  assign busy     = (state != ST_IDLE);
  assign rom_addr = rd_addr;

  // Reads still travelling through the ROM pipeline.
  always_comb begin
    infl = '0;
    for (int i = 0; i < ROMLAT; i++) infl = infl + {3'b000, sv[i]};
  end

  // A slot freed by this cycle's beat can be reused immediately,
  // which keeps one beat per cycle with pready held high.
  assign used     = 4'(fcnt) + infl - {3'b000, beat};
  assign issue_ok = (used < CREDITS);

  // Next-state and ROM read enable.
  always_comb begin
    state_nxt = state;
    rom_me    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && (nump_c != '0)) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        rom_me = issue_ok;
        if (issue_ok && (rd_addr == last_addr)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (beat && plast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, read address counter, load bound and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_addr <= '0;
      rd_addr   <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (start_ok && (nump_c == '0)) || (beat && plast);
      if (start_ok) begin
        last_addr <= nump_c[PADDRW-1:0] - PADDRW'(1);
        rd_addr   <= '0;
      end else if (rom_me && (rd_addr != last_addr)) begin
        rd_addr <= rd_addr + PADDRW'(1);
      end
    end
  end

  // Valid bits of in-flight reads; cleared on reset to drop returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      sv <= '0;
    end else begin
      sv[0] <= rom_me;
      for (int i = 1; i < ROMLAT; i++) sv[i] <= sv[i-1];
    end
  end

  // Address tags travelling alongside the ROM reads.
  always_ff @(posedge clk) begin
    sa[0] <= rd_addr;
    for (int i = 1; i < ROMLAT; i++) sa[i] <= sa[i-1];
  end

  md_pl_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sv[ROMLAT-1]),
    .pop   (beat),
    .wdata ({sa[ROMLAT-1], rom_rdata}),
    .rdata (head),
    .empty (fifo_empty),
    .count (fcnt)
  );

  assign head_addr = head[FW-1 -: PADDRW];
  assign pvalid    = !fifo_empty;
  assign pwe       = pvalid;
  assign paddr     = pvalid ? head_addr : '0;
  assign pwdata    = pvalid ? head[PDATAW-1:0] : '0;
  assign plast     = pvalid && busy && (head_addr == last_addr);

`ifdef MD_PLOADER_STALLCNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles a beat waits on pready.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (pvalid && !pready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign pstall_cnt = stall_q;
`else
  assign pstall_cnt = '0;
`endif

endmodule

// File: tb/tb_md_particle_loader.sv
// Bench for md_particle_loader: ROMLAT=1 and ROMLAT=3 instances
// driven together and checked against a beat-level reference model.
`timescale 1ns/1ps
module tb_md_particle_loader;

  localparam int AW = 12;
  localparam int PW = 125;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic pready;
  logic [AW:0] nump;

  always #5 clk = ~clk;

  logic busy_a, done_a, rom_me_a, pvalid_a, pwe_a, plast_a;
  logic busy_b, done_b, rom_me_b, pvalid_b, pwe_b, plast_b;
  logic [AW-1:0] rom_addr_a, paddr_a, rom_addr_b, paddr_b;
  logic [PW-1:0] rom_rdata_a, pwdata_a, rom_rdata_b, pwdata_b;
  logic [31:0] pstall_a, pstall_b;

  function automatic logic [PW-1:0] romval(input logic [AW-1:0] a);
    int unsigned x;
    x = 32'(a);
    return {32'(x * 32'h9E3779B1), ~x, x ^ 32'h5A5A1234, 29'(x * 7 + 3)};
  endfunction

  md_particle_loader #(.ROMLAT(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .nump(nump),
    .busy(busy_a), .done(done_a), .rom_me(rom_me_a),
    .rom_addr(rom_addr_a), .rom_rdata(rom_rdata_a),
    .pready(pready), .pvalid(pvalid_a), .paddr(paddr_a),
    .pwe(pwe_a), .pwdata(pwdata_a), .plast(plast_a),
    .pstall_cnt(pstall_a)
  );

  md_particle_loader #(.ROMLAT(3)) u_b (
    .clk(clk), .rst(rst), .start(start), .nump(nump),
    .busy(busy_b), .done(done_b), .rom_me(rom_me_b),
    .rom_addr(rom_addr_b), .rom_rdata(rom_rdata_b),
    .pready(pready), .pvalid(pvalid_b), .paddr(paddr_b),
    .pwe(pwe_b), .pwdata(pwdata_b), .plast(plast_b),
    .pstall_cnt(pstall_b)
  );

  // ROM models with 1 and 3 cycle read latency.
  logic [AW-1:0] ra0 = '0;
  logic [AW-1:0] rb0 = '0, rb1 = '0, rb2 = '0;
  always @(posedge clk) begin
    if (rom_me_a) ra0 <= rom_addr_a;
    if (rom_me_b) rb0 <= rom_addr_b;
    rb1 <= rb0;
    rb2 <= rb1;
  end
  assign rom_rdata_a = romval(ra0);
  assign rom_rdata_b = romval(rb2);

  typedef struct {
    logic          busy, done, rom_me;
    logic [AW-1:0] rom_addr;
    logic          pvalid, pwe;
    logic [AW-1:0] paddr;
    logic [PW-1:0] pwdata;
    logic          plast;
    logic [31:0]   pstall;
  } obs_t;

  typedef struct {
    int n;
    int mode;
    int restart_t;
    int exp_beats;
    int exp_done_a;
    int exp_done_b;
    int exp_stall;
  } vec_t;

  int nvec = 0;
  int nmiss = 0;
  int lat [2] = '{1, 3};
  string inm [2] = '{"A", "B"};

  int reads [2], beats [2], t_first [2], t_done [2], ndone [2], t_last [2];
  bit stl [2];
  logic [AW-1:0] h_addr [2];
  logic [PW-1:0] h_data [2];

  function automatic obs_t get_obs(input int i);
    obs_t o;
    if (i == 0)
      o = '{busy_a, done_a, rom_me_a, rom_addr_a, pvalid_a, pwe_a,
            paddr_a, pwdata_a, plast_a, pstall_a};
    else
      o = '{busy_b, done_b, rom_me_b, rom_addr_b, pvalid_b, pwe_b,
            paddr_b, pwdata_b, plast_b, pstall_b};
    return o;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s [%s]: got %0h expected %0h", nm, inm[i], act, exp);
    end
  endtask

  task automatic chk_zero(input int i);
    obs_t o;
    o = get_obs(i);
    chk("rst busy", i, 128'(o.busy), 0);
    chk("rst done", i, 128'(o.done), 0);
    chk("rst rom_me", i, 128'(o.rom_me), 0);
    chk("rst rom_addr", i, 128'(o.rom_addr), 0);
    chk("rst pvalid", i, 128'(o.pvalid), 0);
    chk("rst pwe", i, 128'(o.pwe), 0);
    chk("rst paddr", i, 128'(o.paddr), 0);
    chk("rst pwdata", i, 128'(o.pwdata), 0);
    chk("rst plast", i, 128'(o.plast), 0);
    chk("rst pstall", i, 128'(o.pstall), 0);
  endtask

  // One cycle of the reference model for instance i.
  task automatic observe(input int i, input int t, input int n);
    obs_t o;
    o = get_obs(i);
    if (stl[i]) begin
      chk("pvalid held", i, 128'(o.pvalid), 1);
      chk("paddr held", i, 128'(o.paddr), 128'(h_addr[i]));
      chk("pwdata held", i, 128'(o.pwdata), 128'(h_data[i]));
    end
    if (o.pvalid) begin
      if (t_first[i] < 0) begin
        t_first[i] = t;
        chk("first pvalid cycle", i, 128'(t), 128'(lat[i] + 2));
      end
      chk("pwe", i, 128'(o.pwe), 1);
      chk("paddr order", i, 128'(o.paddr), 128'(beats[i]));
      chk("pwdata", i, 128'(o.pwdata), 128'(romval(AW'(beats[i]))));
      chk("plast", i, 128'(o.plast), 128'(beats[i] == n - 1));
      if (pready) begin
        beats[i]++;
        t_last[i] = t;
        stl[i] = 1'b0;
      end else begin
        stl[i] = 1'b1;
        h_addr[i] = o.paddr;
        h_data[i] = o.pwdata;
      end
    end
    if (o.rom_me) begin
      chk("rom_addr order", i, 128'(o.rom_addr), 128'(reads[i]));
      reads[i]++;
      chk("reads outstanding", i,
          128'((reads[i] - beats[i]) <= lat[i] + 1), 1);
    end
    if (o.done) begin
      ndone[i]++;
      if (t_done[i] < 0) t_done[i] = t;
    end
  endtask

  task automatic run_load(input vec_t v, input int rst_t);
    int t;
    int tail;
    int budget;
    int es;
    obs_t o;
    for (int i = 0; i < 2; i++) begin
      reads[i] = 0; beats[i] = 0; t_first[i] = -1; t_done[i] = -1;
      ndone[i] = 0; t_last[i] = -1; stl[i] = 1'b0;
    end
    budget = 8 * v.exp_beats + 200;
    t = 0;
    tail = 0;
    while (t < budget && tail < 3) begin
      @(negedge clk);
      start = (t == 0) || (t == v.restart_t);
      nump = (t == 0) ? (AW + 1)'(v.n) : (AW + 1)'(3);
      rst = (t == rst_t);
      unique case (v.mode)
        1: pready = t[0];
        2: pready = ($urandom_range(0, 3) != 0);
        3: pready = !(t >= 8 && t < 28);
        default: pready = 1'b1;
      endcase
      #1;
      if (rst_t >= 0 && t == rst_t + 1) begin
        chk_zero(0);
        chk_zero(1);
        return;
      end
      for (int i = 0; i < 2; i++) observe(i, t, v.exp_beats);
      if (t_done[0] >= 0 && t_done[1] >= 0) tail++;
      t++;
    end
    start = 1'b0;
`ifdef MD_PLOADER_STALLCNT_EN
    es = v.exp_stall;
`else
    es = 0;
`endif
    for (int i = 0; i < 2; i++) begin
      o = get_obs(i);
      chk("done seen in budget", i, 128'(t_done[i] >= 0), 1);
      chk("beat count", i, 128'(beats[i]), 128'(v.exp_beats));
      chk("read count", i, 128'(reads[i]), 128'(v.exp_beats));
      chk("done pulses", i, 128'(ndone[i]), 1);
      chk("busy after done", i, 128'(o.busy), 0);
      if (v.exp_beats > 0)
        chk("done after plast", i, 128'(t_done[i]), 128'(t_last[i] + 1));
      else
        chk("no pvalid", i, 128'(t_first[i] + 1), 0);
      if ((i == 0 ? v.exp_done_a : v.exp_done_b) >= 0)
        chk("done cycle", i, 128'(t_done[i]),
            128'(i == 0 ? v.exp_done_a : v.exp_done_b));
      if (es >= 0)
        chk("stall count", i, 128'(o.pstall), 128'(es));
    end
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    tbl = '{
      '{16,   0, -1, 16,   19,   21,   0},
      '{8,    1, -1, 8,    -1,   -1,   7},
      '{0,    0, -1, 0,    1,    1,    0},
      '{5000, 0, -1, 4096, 4099, 4101, 0},
      '{1,    0, -1, 1,    4,    6,    0},
      '{7,    0, 5,  7,    10,   12,   0},
      '{12,   3, -1, 12,   -1,   -1,   -1},
      '{20,   2, -1, 20,   -1,   -1,   -1}
    };
    rst = 1'b1;
    start = 1'b0;
    pready = 1'b0;
    nump = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run_load(tbl[k], -1);

    // Reset while instance A presents beat 10, then a short reload.
    run_load('{16, 0, -1, 16, 19, 21, 0}, 13);
    run_load('{4, 0, -1, 4, 7, 9, 0}, -1);

    for (int r = 0; r < 6; r++) begin
      rv.n = $urandom_range(1, 40);
      rv.mode = 2;
      rv.restart_t = -1;
      rv.exp_beats = rv.n;
      rv.exp_done_a = -1;
      rv.exp_done_b = -1;
      rv.exp_stall = -1;
      run_load(rv, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/md_particle_loader.md
MD_PARTICLE_LOADER -- requirements
Module: md_particle_loader

Interface
REQ-001 SHALL have parameter MAXNUMP, default 32'd4096: maximum particle count (16x16x16 grid).
REQ-002 SHALL have parameter PDATAW, default 32'd125: particle record width (3x4 grid addr + 3x27 oi + 32).
REQ-003 SHALL have parameter ROMLAT, default 32'd1: particle ROM read latency in cycles, legal range 1..3.
REQ-004 SHALL have local parameter PADDRW = $clog2(MAXNUMP).
REQ-005 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port start, input, 1: single-cycle load request.
REQ-008 SHALL have port nump, input, PADDRW+1: particle count to load, sampled with start.
REQ-009 SHALL have port busy, output, 1: load in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when the load completes.
REQ-011 SHALL have port rom_me / rom_addr, output, 1 / PADDRW: particle ROM enable and address.
REQ-012 SHALL have port rom_rdata, input, PDATAW: ROM data, valid ROMLAT cycles after rom_me.
REQ-013 SHALL have port pready, input, 1: accelerator particle memory ready.
REQ-014 SHALL have ports pvalid, paddr, pwe, pwdata, plast, output, 1/PADDRW/1/PDATAW/1: accelerator particle write beat.
REQ-015 SHALL have port pstall_cnt, output, 32: count of stalled beat-cycles.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> DRAIN -> IDLE; start in IDLE with nump>0 -> LOAD; LOAD -> DRAIN once the last ROM read is issued; DRAIN -> IDLE on the plast handshake.
REQ-017 SHALL clamp nump above MAXNUMP to MAXNUMP.
REQ-018 SHALL, for start with nump==0, pulse done exactly 1 cycle later, with no rom_me and no pvalid.
REQ-019 SHALL ignore start while busy; busy = (state != IDLE).
REQ-020 SHALL issue ROM reads at addresses 0..nump-1 in order, one per cycle maximum.
REQ-021 SHALL issue a read only when FIFO occupancy + in-flight reads < ROMLAT+1 (credit rule).
REQ-022 SHALL push returned ROM data, tagged with its address, into a FIFO of depth ROMLAT+1; overflow is impossible by construction.
REQ-023 SHALL drive pvalid = FIFO not empty, and pwe = pvalid.
REQ-024 SHALL drive paddr/pwdata from the FIFO head.
REQ-025 SHALL define a beat transfer as pvalid && pready.
REQ-026 SHALL hold pvalid, paddr and pwdata stable until the beat is accepted.
REQ-027 SHALL assert plast only with the beat whose paddr == nump-1.
REQ-028 SHALL pulse done in the cycle after the plast handshake.
REQ-029 SHALL place the first pvalid exactly ROMLAT+2 cycles after the cycle in which start is sampled.
REQ-030 SHALL sustain 1 beat/cycle with pready held high; total load = nump+ROMLAT+2 cycles to done.
REQ-031 SHALL use modulo-2^PADDRW address arithmetic; the counter never passes nump-1 (no wrap within a load).

Reset
REQ-032 SHALL, on rst, take FSM to IDLE and clear FIFO, credits and address counters.
REQ-033 SHALL, on rst, force busy, done, rom_me, pvalid, pwe, plast = 0; rom_addr, paddr, pwdata, pstall_cnt = 0.
REQ-034 SHALL, on rst mid-load, abort immediately; in-flight ROM returns are discarded; the next start restarts from address 0.

Configuration
REQ-035 SHALL, with MD_PLOADER_STALLCNT_EN defined, clear pstall_cnt on accepted start, increment it (saturating at 2^32-1) each cycle pvalid && !pready, and hold it after done.
REQ-036 SHALL, without MD_PLOADER_STALLCNT_EN, tie pstall_cnt to 0 and synthesize no counter logic.

Structure
REQ-037 SHALL put the FSM state enum typedef and the ROMLAT legal-range constants in shared package md_lr_pkg.
REQ-038 SHALL use one sub-module, md_pl_fifo: synchronous FIFO, parameterized width/depth, first-word-fall-through head.

Verification
REQ-039 SHALL cover ROMLAT=1, nump=16, pready=1: 16 beats, paddr 0..15, plast on 15, done at cycle 19 after start.
REQ-040 SHALL cover pready toggling 1/0 each cycle, nump=8: 8 beats in order, data equal to ROM[paddr], no beat lost or duplicated, pstall_cnt=7 (macro on).
REQ-041 SHALL cover nump=0: done pulse 1 cycle after start, rom_me and pvalid never asserted.
REQ-042 SHALL cover nump=5000 with MAXNUMP=4096: exactly 4096 beats, plast on paddr 4095.
REQ-043 SHALL cover rst asserted on beat 10 of 16 followed by a new start nump=4: all outputs 0 the next cycle, then beats 0..3 only.
REQ-044 SHALL cover ROMLAT=3 with pready low for 20 cycles mid-load: at most 4 reads outstanding, stable held data, ordering preserved.
